// File: rtl/attack_wave_scheduler.sv
// attack_wave_scheduler
// Sequences the four bone generators into timed attack waves separated by
// rest gaps. Once boss health reaches PHASE2_HEALTH it switches from the
// single-generator patterns to the two- and four-generator patterns. It also
// latches the win/loss outcome of the fight.
//
// Optional feature macro: ATTACK_SPEEDUP_EN
//   When defined, a REST taken while in phase 2 lasts max(REST_LEN>>1, 1) ticks.
//
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   asynchronous active-high reset
//   enable        in   run/pause; low freezes all timing and blanks gen_en
//   boss_health   in   [5:0] current boss health-bar length
//   boss_defeated in   boss health exhausted -> WON
//   hit           in   any collision -> LOST (wins over boss_defeated)
//   gen_en        out  [3:0] generator enables {hor2, vert2, hor, vert}
//   state         out  [2:0] IDLE=0 WAVE=1 REST=2 WON=3 LOST=4
//   phase2        out  sticky phase-2 flag
//   wave_count    out  [7:0] waves started, saturating at 255
//   game_over     out  sticky loss
//   game_won      out  sticky win
module attack_wave_scheduler #(
  parameter int unsigned TICK_DIV      = 5_000_000,
  parameter int unsigned WAVE_LEN      = 20,
  parameter int unsigned REST_LEN      = 10,
  parameter int unsigned PHASE2_HEALTH = 30
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] boss_health,
  input  logic       boss_defeated,
  input  logic       hit,
  output logic [3:0] gen_en,
  output logic [2:0] state,
  output logic       phase2,
  output logic [7:0] wave_count,
  output logic       game_over,
  output logic       game_won
);

  localparam int unsigned PW       = $clog2(TICK_DIV);
  localparam int unsigned SLOT_MAX = (WAVE_LEN > REST_LEN) ? WAVE_LEN : REST_LEN;
  localparam int unsigned SW       = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST     = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] WAVE_LAST      = SW'(WAVE_LEN - 1);
  localparam logic [SW-1:0] REST_LAST_FULL = SW'(REST_LEN - 1);
  localparam logic [5:0]    P2_THRESH      = 6'(PHASE2_HEALTH);
`ifdef ATTACK_SPEEDUP_EN
  localparam int unsigned   REST_FAST      = ((REST_LEN >> 1) > 0) ? (REST_LEN >> 1) : 1;
  localparam logic [SW-1:0] REST_LAST_FAST = SW'(REST_FAST - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAVE = 3'd1,
    S_REST = 3'd2,
    S_WON  = 3'd3,
    S_LOST = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [1:0]      pat_idx_q, pat_idx_d;   // index the next wave will use
  logic [3:0]      cur_pat_q, cur_pat_d;   // pattern of the wave in progress
  logic            wave_p2_q, wave_p2_d;   // current wave was started in phase 2
  logic [3:0]      gen_en_q, gen_en_d;
  logic            phase2_q, phase2_d;
  logic [7:0]      wave_count_q, wave_count_d;
  logic            game_over_q, game_over_d;
  logic            game_won_q, game_won_d;

  logic            active_c;
  logic            run_c;
  logic            tick_c;
  logic [SW-1:0]   rest_last_c;

  // Generator enable set for a given phase and pattern index.
  function automatic logic [3:0] pattern(input logic p2, input logic [1:0] idx);
    logic [3:0] p;
    p = 4'b0000;
    if (!p2) begin
      p = idx[0] ? 4'b0010 : 4'b0001;
    end else begin
      case (idx)
        2'd0:    p = 4'b0101;
        2'd1:    p = 4'b1010;
        default: p = 4'b1111;
      endcase
    end
    return p;
  endfunction

  // Timing only advances while running inside a wave or rest.
  assign active_c = (state_q == S_WAVE) || (state_q == S_REST);
  assign run_c    = enable && active_c;
  assign tick_c   = run_c && (presc_q == PRESC_LAST);

  // Rest length, optionally shortened once phase 2 is armed.
  always_comb begin
    rest_last_c = REST_LAST_FULL;
`ifdef ATTACK_SPEEDUP_EN
    if (phase2_q) rest_last_c = REST_LAST_FAST;
`endif
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: hit beats boss_defeated, both beat the timer.
  always_comb begin
    state_d = state_q;
    if (state_q != S_WON && state_q != S_LOST) begin
      if (hit) begin
        state_d = S_LOST;
      end else if (boss_defeated) begin
        state_d = S_WON;
      end else begin
        case (state_q)
          S_IDLE:  if (enable) state_d = S_WAVE;
          S_WAVE:  if (tick_c && slot_q == WAVE_LAST) state_d = S_REST;
          S_REST:  if (tick_c && slot_q == rest_last_c) state_d = S_WAVE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Next values of the counters, pattern bookkeeping and registered outputs.
  always_comb begin
    logic       entering;
    logic [1:0] wave_idx;
    presc_d      = presc_q;
    slot_d       = slot_q;
    pat_idx_d    = pat_idx_q;
    cur_pat_d    = cur_pat_q;
    wave_p2_d    = wave_p2_q;
    wave_count_d = wave_count_q;
    phase2_d     = phase2_q;
    game_over_d  = game_over_q;
    game_won_d   = game_won_q;
    gen_en_d     = 4'b0000;
    wave_idx     = pat_idx_q;
    entering     = (state_d != state_q);

    if (entering) begin
      presc_d = '0;
      slot_d  = '0;
    end else if (tick_c) begin
      presc_d = '0;
      slot_d  = slot_q + SW'(1);
    end else if (run_c) begin
      presc_d = presc_q + PW'(1);
    end

    if (state_q != S_WON && state_q != S_LOST && boss_health <= P2_THRESH)
      phase2_d = 1'b1;

    if (state_d == S_LOST) game_over_d = 1'b1;
    if (state_d == S_WON)  game_won_d  = 1'b1;

    // Pattern is chosen at wave entry; phase 2 restarts the index at 0.
    if (entering && state_d == S_WAVE) begin
      if (phase2_q && !wave_p2_q) wave_idx = 2'd0;
      cur_pat_d = pattern(phase2_q, wave_idx);
      wave_p2_d = phase2_q;
      if (phase2_q) pat_idx_d = (wave_idx == 2'd2) ? 2'd0 : wave_idx + 2'd1;
      else          pat_idx_d = {1'b0, ~wave_idx[0]};
      if (wave_count_q != 8'd255) wave_count_d = wave_count_q + 8'd1;
    end

    if (enable && state_d == S_WAVE) gen_en_d = cur_pat_d;
  end

  // Datapath and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      slot_q       <= '0;
      pat_idx_q    <= 2'd0;
      cur_pat_q    <= 4'b0000;
      wave_p2_q    <= 1'b0;
      gen_en_q     <= 4'b0000;
      phase2_q     <= 1'b0;
      wave_count_q <= 8'd0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      pat_idx_q    <= pat_idx_d;
      cur_pat_q    <= cur_pat_d;
      wave_p2_q    <= wave_p2_d;
      gen_en_q     <= gen_en_d;
      phase2_q     <= phase2_d;
      wave_count_q <= wave_count_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
    end
  end

  assign state      = state_q;
  assign gen_en     = gen_en_q;
  assign phase2     = phase2_q;
  assign wave_count = wave_count_q;
  assign game_over  = game_over_q;
  assign game_won   = game_won_q;

endmodule

// File: doc/attack_wave_scheduler.md
# attack_wave_scheduler

Sequences the four bone generators (vertical, horizontal, second vertical, second horizontal) into timed attack waves separated by rest gaps, and escalates to a two-generator/four-generator pattern set once boss health falls to a threshold. Sits between the top level and the bullet generators: it drives their enables in place of the raw run switch. It also latches the end-of-fight outcome for the colour mux and the VGA plot path.

## Interface

Parameters:
- TICK_DIV, 5_000_000: CLOCK_50 cycles per scheduler tick (0.1 s at 50 MHz); ≥ 2.
- WAVE_LEN, 20: ticks per attack wave; ≥ 1.
- REST_LEN, 10: ticks per rest gap; ≥ 1.
- PHASE2_HEALTH, 30: boss health at or below which phase 2 arms.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run/pause (run switch); low pauses all timing.
- boss_health  in  6  current boss health-bar length.
- boss_defeated  in  1  boss health exhausted.
- hit  in  1  OR of all four collision detectors.
- gen_en  out  4  generator enables: bit0 vert, bit1 hor, bit2 vert_second, bit3 hor_second.
- state  out  3  IDLE=0, WAVE=1, REST=2, WON=3, LOST=4.
- phase2  out  1  sticky phase-2 flag.
- wave_count  out  8  waves started, saturating at 255.
- game_over  out  1  sticky loss.
- game_won  out  1  sticky win.

Reset values: all outputs 0, state IDLE, prescaler 0, slot counter 0, pattern index 0.

## Operation

- All outputs are registered. gen_en is nonzero only in WAVE with enable high.
- **Tick generator:** the prescaler counts 0..TICK_DIV-1 only while enable is high and state is WAVE or REST. A tick is issued when the prescaler equals TICK_DIV-1. The prescaler and slot counter clear on every state entry.
- **Slot counter:** increments on each tick. A tick that finds it at LEN-1 causes the state transition.

State transitions:
- IDLE -> WAVE on the first edge with enable high.
- WAVE -> REST on the final tick.
- REST -> WAVE on the final tick.
- WON and LOST are absorbing until reset.

Pattern on WAVE entry:
- Phase 1: pattern index alternates 0,1. Index 0 gives gen_en=4'b0001; index 1 gives 4'b0010.
- Phase 2: pattern index cycles 0,1,2. Index 0 gives 4'b0101; index 1 gives 4'b1010; index 2 gives 4'b1111.

phase2 handling:
- phase2 sets when boss_health ≤ PHASE2_HEALTH in any non-terminal state.
- phase2 takes effect only at the next WAVE entry. A wave in progress keeps its pattern.
- The first phase-2 wave uses index 0 (the index resets when phase2 first applies).

wave_count increments on every WAVE entry.

Events and priority (highest first):
- **hit:** state -> LOST, game_over=1, gen_en=0 on the next edge.
- **boss_defeated:** state -> WON, game_won=1, gen_en=0 on the next edge.
- **Timer transitions:** lowest priority.
- hit and boss_defeated in the same cycle: LOST.
- hit and boss_defeated are honoured in every non-terminal state, including IDLE and while paused.

enable low (pause):
- gen_en forced to 0 on the next edge.
- Prescaler, slot counter, pattern index and state hold.
- When enable returns high, gen_en restores the current wave's pattern on the next edge and timing resumes from the held counts.

Reset mid-operation clears everything immediately, including the terminal flags.

## Timing

- Enable rises in IDLE: gen_en, state=WAVE and wave_count=1 appear 1 edge later.
- WAVE lasts exactly TICK_DIV×WAVE_LEN enabled cycles; REST lasts TICK_DIV×REST_LEN enabled cycles (see Configuration for the phase-2 override).
- gen_en drops on the same edge state becomes REST, and rises on the same edge state becomes WAVE.
- hit or boss_defeated to the terminal outputs: 1 edge.
- Counter widths: prescaler is $clog2(TICK_DIV) bits; slot counter is $clog2(max(WAVE_LEN,REST_LEN)) bits, minimum 1.

## Configuration

- `ATTACK_SPEEDUP_EN` defined: in phase 2, each REST lasts max(REST_LEN>>1, 1) ticks. WAVE length is unchanged.
- `ATTACK_SPEEDUP_EN` undefined: REST is always REST_LEN ticks.

## Test plan

Bench parameters TICK_DIV=4, WAVE_LEN=3, REST_LEN=2, PHASE2_HEALTH=30.

- Reset, enable=1, boss_health=63 -> 1 edge later state=1, gen_en=0001, wave_count=1. After 12 cycles: state=2, gen_en=0. After a further 8 cycles: gen_en=0010, wave_count=2.
- During the first wave, drop boss_health to 30 -> phase2=1 next edge, wave 1 keeps 0001. Following waves give 0101, 1010, 1111, 0101. Without `ATTACK_SPEEDUP_EN` each rest is 8 cycles; with it defined, each phase-2 rest is 4 cycles.
- Mid-wave after 5 cycles, enable=0 for 50 cycles -> gen_en=0 with counters frozen. Re-enable -> gen_en restored next edge, and the wave ends exactly 7 enabled cycles later.
- Assert hit and boss_defeated in the same cycle during REST -> state=4, game_over=1, game_won=0, gen_en=0. Both stay unchanged for 100 cycles with enable toggling.
- Assert boss_defeated alone in IDLE with enable=0 -> state=3, game_won=1. Then assert reset asynchronously mid-cycle -> all outputs 0 immediately, before the next edge.
- Hold enable high for 256+ waves -> wave_count saturates at 255 while gen_en keeps cycling its pattern.
